hazard_scoreboard: RTL and testbench

- Parametrised successor to the fixed EX/MEM-compare hazard detector.
- Tracks every architectural register with per-register countdown counters, so it supports variable-latency producers (ALU, load, multi-cycle units) at any pipeline depth.
- Sits in decode: compares the decode instruction's sources against the scoreboard and raises the decode stall.
- Records the issuing instruction's destination when the instruction leaves decode.

---
 rtl/hazard_pkg.sv | 21 ++
 rtl/hazard_sb_entry.sv | 42 ++++
 rtl/hazard_scoreboard.sv | 117 +++++++++++
 tb/tb_hazard_scoreboard.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared latency type, standard producer latencies and default zero-register policy.
// Revision: 1.0
`default_nettype none

package hazard_pkg;

  localparam int LAT_W_DEF = 3;
  typedef logic [LAT_W_DEF-1:0] lat_t;

  localparam lat_t LAT_ALU_FWD  = 3'd1;
  localparam lat_t LAT_ALU_WB   = 3'd1;
  localparam lat_t LAT_LOAD_FWD = 3'd2;
  localparam lat_t LAT_LOAD_WB  = 3'd2;
  localparam lat_t LAT_MUL_FWD  = 3'd3;
  localparam lat_t LAT_MUL_WB   = 3'd4;

  localparam bit ZERO_REG_DEF = 1'b1;

endpackage

`default_nettype wire

// File: rtl/hazard_sb_entry.sv
// hazard_sb_entry: one register's forward/writeback countdown pair with load-over-decrement.
// Revision: 1.0
`default_nettype none

module hazard_sb_entry #(
  parameter int LAT_W = 3
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [LAT_W-1:0] i_fwd_lat,
  input  logic [LAT_W-1:0] i_wb_lat,
  output logic             o_fwd_rdy,
  output logic             o_wb_rdy
);

  logic [LAT_W-1:0] r_fwd_cnt;
  logic [LAT_W-1:0] r_wb_cnt;
  logic [LAT_W-1:0] w_fwd_load;

  // A result can never be forwardable later than it lands in the register file.
  assign w_fwd_load = (i_fwd_lat < i_wb_lat) ? i_fwd_lat : i_wb_lat;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fwd_cnt <= '0;
      r_wb_cnt  <= '0;
    end else if (i_load) begin
      r_fwd_cnt <= w_fwd_load;
      r_wb_cnt  <= i_wb_lat;
    end else begin
      if (r_fwd_cnt != '0) r_fwd_cnt <= r_fwd_cnt - 1'b1;
      if (r_wb_cnt != '0)  r_wb_cnt  <= r_wb_cnt - 1'b1;
    end
  end

  assign o_fwd_rdy = (r_fwd_cnt == '0);
  assign o_wb_rdy  = (r_wb_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: decode-stage RAW stall detection over per-register latency counters.
// Optional HAZARD_PERF_EN adds stall-cycle performance counters. Revision: 1.0
`default_nettype none

module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_REGS   = 32,
  parameter int LAT_W      = 3,
  parameter bit ZERO_REG   = ZERO_REG_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [REG_ADDR_W-1:0] i_src1,
  input  logic [REG_ADDR_W-1:0] i_src2,
  input  logic                  i_src1_used,
  input  logic                  i_src2_used,
  input  logic                  i_forward_EN,
  input  logic                  i_Branch,
  input  logic                  i_id_valid,
  input  logic                  i_flush,
  input  logic                  i_REGWrite,
  input  logic [REG_ADDR_W-1:0] i_dst,
  input  logic [LAT_W-1:0]      i_fwd_lat,
  input  logic [LAT_W-1:0]      i_wb_lat,
  output logic                  o_hazard_detected,
  output logic                  o_src1_stall,
  output logic                  o_src2_stall,
  output logic                  o_busy
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]           o_stall_cycles,
  output logic [31:0]           o_branch_stall_cycles
`endif
);

  logic [NUM_REGS-1:0] w_fwd_rdy;
  logic [NUM_REGS-1:0] w_wb_rdy;
  logic                w_issue;
  logic                w_need_wb;
  logic                w_src1_fwd_rdy, w_src1_wb_rdy;
  logic                w_src2_fwd_rdy, w_src2_wb_rdy;

  genvar g;
  generate
    for (g = 0; g < NUM_REGS; g++) begin : g_reg
      if (ZERO_REG && (g == 0)) begin : g_zero
        assign w_fwd_rdy[g] = 1'b1;
        assign w_wb_rdy[g]  = 1'b1;
      end else begin : g_entry
        logic w_load;
        assign w_load = w_issue & i_REGWrite & (i_dst == REG_ADDR_W'(g));
        hazard_sb_entry #(.LAT_W(LAT_W)) u_entry (
          .i_clk     (i_clk),
          .i_rst_n   (i_rst_n),
          .i_load    (w_load),
          .i_fwd_lat (i_fwd_lat),
          .i_wb_lat  (i_wb_lat),
          .o_fwd_rdy (w_fwd_rdy[g]),
          .o_wb_rdy  (w_wb_rdy[g])
        );
      end
    end
  endgenerate

  // Indices beyond NUM_REGS match no entry and therefore read as ready.
  always_comb begin
    w_src1_fwd_rdy = 1'b1;
    w_src1_wb_rdy  = 1'b1;
    w_src2_fwd_rdy = 1'b1;
    w_src2_wb_rdy  = 1'b1;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (i_src1 == REG_ADDR_W'(r)) begin
        w_src1_fwd_rdy = w_fwd_rdy[r];
        w_src1_wb_rdy  = w_wb_rdy[r];
      end
      if (i_src2 == REG_ADDR_W'(r)) begin
        w_src2_fwd_rdy = w_fwd_rdy[r];
        w_src2_wb_rdy  = w_wb_rdy[r];
      end
    end
  end

  // Branches resolve in decode and read the register file directly.
  assign w_need_wb = ~i_forward_EN | i_Branch;

  assign o_src1_stall = i_id_valid & i_src1_used &
                        ~(w_need_wb ? w_src1_wb_rdy : w_src1_fwd_rdy);
  assign o_src2_stall = i_id_valid & i_src2_used &
                        ~(w_need_wb ? w_src2_wb_rdy : w_src2_fwd_rdy);
  assign o_hazard_detected = o_src1_stall | o_src2_stall;

  assign w_issue = i_id_valid & ~o_hazard_detected & ~i_flush;
  assign o_busy  = ~&w_wb_rdy;

`ifdef HAZARD_PERF_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_branch_stall_cycles;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stall_cycles        <= '0;
      r_branch_stall_cycles <= '0;
    end else if (o_hazard_detected) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
      if (i_Branch) r_branch_stall_cycles <= r_branch_stall_cycles + 32'd1;
    end
  end

  assign o_stall_cycles        = r_stall_cycles;
  assign o_branch_stall_cycles = r_branch_stall_cycles;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed and random stimulus against a ready-time reference model.
// Revision: 1.0
`default_nettype none

module tb_hazard_scoreboard;
  import hazard_pkg::*;

  localparam int AW = 5;
  localparam int NR = 24;
  localparam int LW = 3;

  typedef struct {
    logic [AW-1:0] src1, src2, dst;
    logic          u1, u2, fwd_en, br, valid, flush, wr;
    logic [LW-1:0] fl, wl;
  } stim_t;

  typedef struct {
    logic haz, s1, s2, busy;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] src1 = '0, src2 = '0, dst = '0;
  logic          u1 = 1'b0, u2 = 1'b0, fwd_en = 1'b0, br = 1'b0;
  logic          valid = 1'b0, flush = 1'b0, wr = 1'b0;
  logic [LW-1:0] fl = '0, wl = '0;
  logic          haz, s1_stall, s2_stall, busy;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   fwd_at[NR];
  int   wb_at[NR];
  exp_t exp_q[$];

  hazard_scoreboard #(.REG_ADDR_W(AW), .NUM_REGS(NR), .LAT_W(LW), .ZERO_REG(1'b1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_src1(src1), .i_src2(src2),
    .i_src1_used(u1), .i_src2_used(u2), .i_forward_EN(fwd_en), .i_Branch(br),
    .i_id_valid(valid), .i_flush(flush), .i_REGWrite(wr), .i_dst(dst),
    .i_fwd_lat(fl), .i_wb_lat(wl), .o_hazard_detected(haz),
    .o_src1_stall(s1_stall), .o_src2_stall(s2_stall), .o_busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // A producer issued in cycle m with latency L becomes ready in cycle m+1+L.
  function automatic bit model_ready(input int r, input bit use_wb);
    if (r >= NR || r == 0) return 1'b1;
    return use_wb ? (cyc >= wb_at[r]) : (cyc >= fwd_at[r]);
  endfunction

  function automatic bit model_busy();
    for (int r = 1; r < NR; r++) if (wb_at[r] > cyc) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < NR; r++) begin
      fwd_at[r] = 0;
      wb_at[r]  = 0;
    end
  endtask

  task automatic check(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %b expected %b", name, cyc, act, req);
    end
  endtask

  task automatic step(input stim_t s);
    exp_t e;
    bit   need_wb, issue;
    @(negedge clk);
    src1 = s.src1; src2 = s.src2; dst = s.dst; u1 = s.u1; u2 = s.u2;
    fwd_en = s.fwd_en; br = s.br; valid = s.valid; flush = s.flush;
    wr = s.wr; fl = s.fl; wl = s.wl;
    need_wb = !s.fwd_en || s.br;
    e.s1   = s.valid && s.u1 && !model_ready(int'(s.src1), need_wb);
    e.s2   = s.valid && s.u2 && !model_ready(int'(s.src2), need_wb);
    e.haz  = e.s1 || e.s2;
    e.busy = model_busy();
    exp_q.push_back(e);
    issue = s.valid && !e.haz && !s.flush;
    if (issue && s.wr && int'(s.dst) < NR && s.dst != 0) begin
      wb_at[s.dst]  = cyc + 1 + int'(s.wl);
      fwd_at[s.dst] = cyc + 1 + ((s.fl < s.wl) ? int'(s.fl) : int'(s.wl));
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{src1:'0, src2:'0, dst:'0, u1:0, u2:0, fwd_en:1, br:0,
          valid:0, flush:0, wr:0, fl:'0, wl:'0};
    return s;
  endfunction

  function automatic stim_t wr_op(input int d, input int f, input int w);
    stim_t s;
    s = idle();
    s.valid = 1; s.wr = 1; s.dst = AW'(d); s.fl = LW'(f); s.wl = LW'(w);
    return s;
  endfunction

  function automatic stim_t rd_op(input int a, input int b, input bit ua, input bit ub,
                                  input bit fe, input bit bra);
    stim_t s;
    s = idle();
    s.valid = 1; s.src1 = AW'(a); s.src2 = AW'(b);
    s.u1 = ua; s.u2 = ub; s.fwd_en = fe; s.br = bra;
    return s;
  endfunction

  // Monitor: every stimulus cycle's expectation is compared a little after the inputs settle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("hazard", haz, e.haz);
        check("src1_stall", s1_stall, e.s1);
        check("src2_stall", s2_stall, e.s2);
        check("busy", busy, e.busy);
      end
    end
  end

  initial begin
    stim_t s;
    model_clear();
    #1;
    check("reset_hazard", haz, 1'b0);
    check("reset_busy", busy, 1'b0);
    #20 rst_n = 1'b1;

    // Forwarded ALU RAW, then the same with forwarding disabled
    step(wr_op(5, 1, 3));
    for (int i = 0; i < 3; i++) step(rd_op(5, 0, 1, 0, 1, 0));
    step(wr_op(5, 1, 3));
    for (int i = 0; i < 4; i++) step(rd_op(5, 0, 1, 0, 0, 0));

    // Branch on src2 waits for writeback
    step(wr_op(7, 1, 3));
    for (int i = 0; i < 4; i++) step(rd_op(0, 7, 0, 1, 1, 1));

    // Unused pending source, zero register, standard multiplier latency
    step(wr_op(7, 1, 3));
    step(rd_op(0, 7, 0, 0, 0, 0));
    step(wr_op(0, 4, 4));
    for (int i = 0; i < 3; i++) step(rd_op(0, 0, 1, 1, 0, 1));
    step(wr_op(11, int'(LAT_MUL_FWD), int'(LAT_MUL_WB)));
    for (int i = 0; i < 5; i++) step(rd_op(11, 11, 1, 1, 1, 0));

    // WAW: newest producer wins
    step(wr_op(9, 6, 6));
    step(idle());
    step(wr_op(9, 1, 1));
    for (int i = 0; i < 3; i++) step(rd_op(9, 0, 1, 0, 0, 0));

    // Flushed write is not recorded
    s = wr_op(4, 3, 3);
    s.flush = 1;
    step(s);
    step(rd_op(4, 4, 1, 1, 0, 1));

    // Out-of-range destination and source
    step(wr_op(30, 5, 5));
    step(rd_op(30, 23, 1, 1, 0, 0));

    // Asynchronous reset with r3 pending and a dependent instruction in decode
    step(wr_op(3, 2, 4));
    step(rd_op(3, 3, 1, 1, 0, 0));
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_hazard", haz, 1'b0);
    check("async_rst_busy", busy, 1'b0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 400; i++) begin
      s.src1   = AW'($urandom_range(0, (i % 16 == 0) ? 31 : 12));
      s.src2   = AW'($urandom_range(0, 12));
      s.dst    = AW'($urandom_range(0, (i % 20 == 0) ? 31 : 12));
      s.u1     = 1'($urandom);
      s.u2     = 1'($urandom);
      s.fwd_en = ($urandom_range(0, 3) != 0);
      s.br     = ($urandom_range(0, 4) == 0);
      s.valid  = ($urandom_range(0, 5) != 0);
      s.flush  = ($urandom_range(0, 9) == 0);
      s.wr     = ($urandom_range(0, 3) != 0);
      s.fl     = LW'($urandom);
      s.wl     = LW'($urandom);
      step(s);
    end

    step(idle());
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
